// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, decode IR, execute T3-T6 strobes for the single-bus datapath.
// Latency from T0: ALU3 6 cycles, mul/div 7, unary 5, nop/illegal 4; outputs combinational from state+IR.
// No backpressure: one step per clock; run sampled only in IDLE and in the done cycle, clr aborts anywhere.
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        incPC,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        ZLowOut,
    output logic        ZHighOut,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  opcode,
    output logic        done,
    output logic        halted,
    output logic        ill_op
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t state_q, state_d;

    logic [4:0]  op;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    logic        is_alu3, is_md, is_un, is_nop, is_halt, is_ill;
    logic        unused_ir_bits;

    assign op    = IR[31:27];
    assign ra_oh = 16'b1 << IR[26:23];
    assign rb_oh = 16'b1 << IR[22:19];
    assign rc_oh = 16'b1 << IR[18:15];
    assign unused_ir_bits = ^IR[14:0];

    // Opcode class decode; anything not in a class is illegal and runs as a nop.
    always_comb begin
        is_alu3 = (op >= 5'b00011) && (op <= 5'b01011);
        is_md   = (op == 5'b01111) || (op == 5'b10000);
        is_un   = (op == 5'b10001) || (op == 5'b10010);
        is_nop  = (op == 5'b11010);
        is_halt = (op == 5'b11011);
        is_ill  = !(is_alu3 || is_md || is_un || is_nop || is_halt);
    end

    // State register; clr forces IDLE immediately, which also zeroes every output.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and strobe decode for each step.
    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        MARin    = 1'b0;
        incPC    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        ZLowOut  = 1'b0;
        ZHighOut = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rin      = 16'h0000;
        Rout     = 16'h0000;
        opcode   = 5'b00000;
        done     = 1'b0;
        halted   = 1'b0;
        ill_op   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                incPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                ZLowOut = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (is_alu3) begin
                    Rout    = rb_oh;
                    Yin     = 1'b1;
                    state_d = S_T4;
                end else if (is_md) begin
                    Rout    = ra_oh;
                    Yin     = 1'b1;
                    state_d = S_T4;
                end else if (is_un) begin
                    Rout    = rb_oh;
                    Zin     = 1'b1;
                    opcode  = op;
                    state_d = S_T4;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    done   = 1'b1;
                    ill_op = is_ill;
                end
            end
            S_T4: begin
                if (is_alu3) begin
                    Rout    = rc_oh;
                    Zin     = 1'b1;
                    opcode  = op;
                    state_d = S_T5;
                end else if (is_md) begin
                    Rout    = rb_oh;
                    Zin     = 1'b1;
                    opcode  = op;
                    state_d = S_T5;
                end else if (is_un) begin
                    ZLowOut = 1'b1;
                    Rin     = ra_oh;
                    done    = 1'b1;
                end else begin
                    // IR no longer names a class with this step: abandon quietly.
                    state_d = S_IDLE;
                end
            end
            S_T5: begin
                if (is_alu3) begin
                    ZLowOut = 1'b1;
                    Rin     = ra_oh;
                    done    = 1'b1;
                end else if (is_md) begin
                    ZLowOut = 1'b1;
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T6: begin
                if (is_md) begin
                    ZHighOut = 1'b1;
                    HIin     = 1'b1;
                    done     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // run is only consulted at the end of an instruction.
        if (done) state_d = run ? S_T0 : S_IDLE;
    end

endmodule
